// File: rtl/i2c_reg_arbiter.sv
// Round-robin arbiter that sequences the I2C byte engine for single-register
// write/read accesses. Define I2C_TIMEOUT_EN to enable the per-byte watchdog.
module i2c_reg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ-1:0]   req_hs,
  input  logic [7*NUM_REQ-1:0] req_dev,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [2:0]           rsp_err,
  output logic                 cmd_active,
  output logic                 cmd_high_speed,
  output logic [6:0]           cmd_addr,
  output logic                 cmd_read,
  output logic                 read_nack,
  input  logic                 addr_err,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [7:0]           data_in,
  input  logic [7:0]           data_out,
  input  logic                 data_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, W_REG, W_DATA, GAP_RD, RD, STOP, RESP} state_e;

  state_e        state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] grant_q;
  logic          write_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_q;
  logic [2:0]    err_q;
  logic [GW-1:0] gap_q;

  logic          grantFound;
  logic [IW-1:0] grantIdx;
  logic [6:0]    selDev;
  logic [7:0]    selReg;
  logic [7:0]    selWdata;
  logic          selWrite;
  logic          selHs;
  logic          byteActive;
  logic          tmoHit;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grantFound && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        grantFound = 1'b1;
        grantIdx   = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    selDev   = req_dev[7*int'(grantIdx) +: 7];
    selReg   = req_reg[8*int'(grantIdx) +: 8];
    selWdata = req_wdata[8*int'(grantIdx) +: 8];
    selWrite = req_write[grantIdx];
    selHs    = req_hs[grantIdx];
  end

  assign req_ack = (state_q == IDLE && grantFound && !reset) ?
                   (NUM_REQ'(1) << grantIdx) : '0;

  assign byteActive = (state_q == W_REG) || (state_q == W_DATA) || (state_q == RD);

`ifdef I2C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;

  // Every exit from a byte state happens on data_ready or a timeout, so those
  // plus the idle states cover all state changes.
  always_ff @(posedge clk) begin
    if (reset || !byteActive || data_ready || tmoHit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmoHit = byteActive && !data_ready && (tmo_q == TmoLast);
`else
  assign tmoHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_q           <= IW'(NUM_REQ - 1);
      grant_q        <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      err_q          <= '0;
      gap_q          <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= '0;
      cmd_active     <= 1'b0;
      cmd_high_speed <= 1'b0;
      cmd_addr       <= '0;
      cmd_read       <= 1'b0;
      read_nack      <= 1'b0;
      data_valid     <= 1'b0;
      data_in        <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            grant_q        <= grantIdx;
            rr_q           <= grantIdx;
            write_q        <= selWrite;
            wdata_q        <= selWdata;
            rdata_q        <= '0;
            err_q          <= '0;
            cmd_addr       <= selDev;
            cmd_high_speed <= selHs;
            cmd_active     <= 1'b1;
            cmd_read       <= 1'b0;
            data_valid     <= 1'b1;
            data_in        <= selReg;
            state_q        <= W_REG;
          end
        end
        W_REG: begin
          if (data_ready) begin
            err_q <= {1'b0, data_err, addr_err};
            if (addr_err || data_err) begin
              cmd_active <= 1'b0;
              data_valid <= 1'b0;
              gap_q      <= '0;
              state_q    <= STOP;
            end else if (write_q) begin
              data_in <= wdata_q;
              state_q <= W_DATA;
            end else begin
              cmd_active <= 1'b0;
              data_valid <= 1'b0;
              gap_q      <= '0;
              state_q    <= GAP_RD;
            end
          end else if (tmoHit) begin
            err_q[2]   <= 1'b1;
            cmd_active <= 1'b0;
            data_valid <= 1'b0;
            gap_q      <= '0;
            state_q    <= STOP;
          end
        end
        W_DATA: begin
          if (data_ready || tmoHit) begin
            err_q[1]   <= err_q[1] | (data_ready & data_err);
            err_q[2]   <= err_q[2] | tmoHit;
            cmd_active <= 1'b0;
            data_valid <= 1'b0;
            gap_q      <= '0;
            state_q    <= STOP;
          end
        end
        GAP_RD: begin
          if (gap_q == GapLast) begin
            cmd_active <= 1'b1;
            cmd_read   <= 1'b1;
            read_nack  <= 1'b1;
            data_valid <= 1'b1;
            state_q    <= RD;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        // Address NACK on the read phase still returns whatever byte arrived.
        RD: begin
          if (data_ready || tmoHit) begin
            if (data_ready) begin
              rdata_q <= data_out;
            end
            err_q[0]   <= err_q[0] | (data_ready & addr_err);
            err_q[2]   <= err_q[2] | tmoHit;
            cmd_active <= 1'b0;
            cmd_read   <= 1'b0;
            read_nack  <= 1'b0;
            data_valid <= 1'b0;
            gap_q      <= '0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (gap_q == GapLast) begin
            rsp_valid <= NUM_REQ'(1) << grant_q;
            rsp_rdata <= rdata_q;
            rsp_err   <= err_q;
            state_q   <= RESP;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        RESP: begin
          rsp_rdata      <= '0;
          rsp_err        <= '0;
          cmd_addr       <= '0;
          cmd_high_speed <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
